// File: rtl/mandelbrot_pkg.sv
// rtl/mandelbrot_pkg.sv - shared constants and state encoding for the Mandelbrot engine
package mandelbrot_pkg;

    localparam int DEFAULT_WIDTH        = 32;
    localparam int DEFAULT_FRAC         = 24;
    localparam int ESCAPE_RADIUS_SQ_INT = 4;

    // State register encoding; plain constants keep older tools happy
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t ITER = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/mandelbrot_engine_fixed_mul.sv
// rtl/mandelbrot_engine_fixed_mul.sv - signed fixed-point multiply, rescaled and truncated to WIDTH
module fixed_mul
    import mandelbrot_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int FRAC  = DEFAULT_FRAC
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] p
);

    logic signed [2*WIDTH-1:0] full;

    // Full-precision product, then drop FRAC fraction bits keeping sign
    always_comb begin
        full = a * b;
        p    = WIDTH'(full >>> FRAC);
    end

endmodule

// File: rtl/mandelbrot_engine.sv
// rtl/mandelbrot_engine.sv - handshaked Mandelbrot pixel engine, one iteration per clock
module mandelbrot_engine
    import mandelbrot_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int FRAC   = DEFAULT_FRAC,
    parameter int ITER_W = 16,
    parameter int TAG_W  = 22
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] c_real,
    input  logic signed [WIDTH-1:0] c_imag,
    input  logic [ITER_W-1:0]       max_iter,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ITER_W-1:0]       out_count,
    output logic                    out_escaped,
    output logic [TAG_W-1:0]        out_tag
);

    localparam logic signed [WIDTH:0] ESC_LIM = ((WIDTH+1)'(ESCAPE_RADIUS_SQ_INT)) << FRAC;

    state_t                  state;
    logic signed [WIDTH-1:0] zr, zi, cr_q, ci_q;
    logic [ITER_W-1:0]       k, max_q;
    logic [TAG_W-1:0]        tag_q;
    logic signed [WIDTH-1:0] sq_r, sq_i, mix;
    logic signed [WIDTH:0]   size;
    logic                    escape;

    fixed_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_rr (.a(zr), .b(zr), .p(sq_r));
    fixed_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_ii (.a(zi), .b(zi), .p(sq_i));
    fixed_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_ri (.a(zr), .b(zi), .p(mix));

    // |z|^2 in one extra bit so the sum of two near-limit squares cannot wrap
    always_comb begin
        size   = {sq_r[WIDTH-1], sq_r} + {sq_i[WIDTH-1], sq_i};
        escape = (size > ESC_LIM);
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Accept / iterate / hold-result control with the datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            zr          <= '0;
            zi          <= '0;
            k           <= '0;
            cr_q        <= '0;
            ci_q        <= '0;
            max_q       <= '0;
            tag_q       <= '0;
            out_count   <= '0;
            out_escaped <= 1'b0;
            out_tag     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cr_q  <= c_real;
                        ci_q  <= c_imag;
                        max_q <= max_iter;
                        tag_q <= in_tag;
                        zr    <= '0;
                        zi    <= '0;
                        k     <= '0;
                        state <= ITER;
                    end
                end
                ITER: begin
                    // Escape wins over the iteration limit when both hold
                    if (escape) begin
                        out_count   <= k;
                        out_escaped <= 1'b1;
                        out_tag     <= tag_q;
                        state       <= DONE;
                    end else if (k == max_q) begin
                        out_count   <= max_q;
                        out_escaped <= 1'b0;
                        out_tag     <= tag_q;
                        state       <= DONE;
                    end else begin
                        zr <= sq_r - sq_i + cr_q;
                        zi <= {mix[WIDTH-2:0], 1'b0} + ci_q;
                        k  <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_engine.sv
// tb/tb_mandelbrot_engine.sv - directed self-checking bench for mandelbrot_engine
module tb_mandelbrot_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] c_real, c_imag;
    logic [15:0] max_iter;
    logic [21:0] in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_count;
    logic        out_escaped;
    logic [21:0] out_tag;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] ONE     = 32'h0100_0000;
    localparam logic [31:0] TWO     = 32'h0200_0000;
    localparam logic [31:0] NEG_TWO = 32'hFE00_0000;

    mandelbrot_engine dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .c_real     (c_real),
        .c_imag     (c_imag),
        .max_iter   (max_iter),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .out_escaped(out_escaped),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Present one pixel, wait for its result and check latency/result; optionally hand it off
    task automatic run_pixel(input string name, input logic [31:0] cr, input logic [31:0] ci,
                             input logic [15:0] mi, input logic [21:0] tg,
                             input int exp_cnt, input logic exp_esc, input bit release_it);
        int cyc;
        @(negedge clk);
        c_real = cr; c_imag = ci; max_iter = mi; in_tag = tg; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        c_real = $urandom; c_imag = $urandom; max_iter = 16'(exp_cnt + 3); in_tag = ~tg;
        cyc = 1;
        check({name, "_busy"}, 64'(in_ready), 64'd0);
        while (!out_valid && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc), 64'(exp_cnt + 2));
        check({name, "_count"}, 64'(out_count), 64'(exp_cnt));
        check({name, "_escaped"}, 64'(out_escaped), 64'(exp_esc));
        check({name, "_tag"}, 64'(out_tag), 64'(tg));
        if (release_it) begin
            @(negedge clk); out_ready = 1'b1;
            @(posedge clk); #1; out_ready = 1'b0;
            check({name, "_released"}, 64'(out_valid), 64'd0);
            check({name, "_ready_again"}, 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        c_real = '0; c_imag = '0; max_iter = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(out_count), 64'd0);
        check("rst_escaped", 64'(out_escaped), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("idle_no_accept", 64'(in_ready), 64'd1);

        run_pixel("origin",   32'd0, 32'd0, 16'd50,  22'h00011, 50,  1'b0, 1'b1);
        run_pixel("two",      TWO,   32'd0, 16'd100, 22'h00022, 2,   1'b1, 1'b1);
        run_pixel("one_one",  ONE,   ONE,   16'd100, 22'h00033, 2,   1'b1, 1'b1);
        run_pixel("neg_two",  NEG_TWO, 32'd0, 16'd100, 22'h00044, 100, 1'b0, 1'b1);
        run_pixel("zero_max", TWO,   ONE,   16'd0,   22'h2A5A5, 0,   1'b0, 1'b1);

        // Result held while the consumer stalls; new requests are ignored
        run_pixel("hold", ONE, ONE, 16'd100, 22'h12345, 2, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0]; c_real = 32'd0; c_imag = 32'd0; max_iter = 16'd7; in_tag = 22'h3FFFF;
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_count", 64'(out_count), 64'd2);
            check("hold_escaped", 64'(out_escaped), 64'd1);
            check("hold_tag", 64'(out_tag), 64'h12345);
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check("hold_release_valid", 64'(out_valid), 64'd0);
        check("hold_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        check("hold_no_stale_accept", 64'(in_ready), 64'd1);

        // Reset during iteration drops the pixel
        @(negedge clk);
        c_real = NEG_TWO; c_imag = 32'd0; max_iter = 16'd100; in_tag = 22'h00055; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("midrst_quiet", 64'({out_valid, in_ready}), 64'b01);
        end
        run_pixel("after_rst", TWO, 32'd0, 16'd100, 22'h00066, 2, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
